// File: rtl/cnt10_counter.sv
// Synchronous 4-bit decade counter: enable, parallel load and terminal-count carry.
// Cascade stages by wiring one stage's cout into the next stage's en.
module cnt10_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       cout
);

   logic [3:0] r_q;
   logic [3:0] w_q_inc;
   logic       w_wrap;
   logic       w_term;

   // Any value from 9 upward, including out-of-range loads, wraps to 0.
   assign w_wrap  = (r_q >= 4'd9);
   assign w_q_inc = w_wrap ? '0 : r_q + 4'd1;
   assign w_term  = (r_q == 4'd9);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= d;
      end else if (en) begin
         r_q <= w_q_inc;
      end
   end

   assign q    = r_q;
   assign cout = en & w_term;

endmodule

// File: tb/tb_cnt10_counter.sv
// Scoreboard bench for cnt10_counter: directed scenarios plus random stimulus,
// checked against a rule-level reference model.
module tb_cnt10_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] d;
   logic [3:0] q;
   logic       cout;

   cnt10_counter dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .load (load),
      .d    (d),
      .q    (q),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned q_exp;
      bit          cout_exp;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned model_q = 0;
   bit          run_count = 1'b0;
   int unsigned cout_seen = 0;

   function automatic int unsigned model_next(int unsigned cur, bit r, bit l, bit e, int unsigned dv);
      if (r)      return 0;
      else if (l) return dv;
      else if (e) return (cur < 9) ? cur + 1 : 0;
      else        return cur;
   endfunction

   task automatic check(string name, int unsigned act, int unsigned req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   // Called at posedge+1: drives one cycle's inputs, queues the expectation
   // for this cycle (state before the edge), advances the model.
   task automatic step(bit r, bit l, bit e, int unsigned dv, string tag);
      exp_t x;
      rst  = r;
      load = l;
      en   = e;
      d    = 4'(dv);
      x.q_exp    = model_q;
      x.cout_exp = e && (model_q == 9);
      x.tag      = tag;
      sb.push_back(x);
      model_q = model_next(model_q, r, l, e, dv);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every falling edge compares the DUT against the oldest expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         check({x.tag, "_q"}, int'(q), x.q_exp);
         check({x.tag, "_cout"}, int'(cout), int'(x.cout_exp));
      end
      if (run_count && cout) cout_seen++;
   end

   initial begin
      int unsigned guard;
      rst = 1'b1; en = 1'b0; load = 1'b0; d = 4'd5;
      @(posedge clk);
      #1;
      model_q = 0;

      step(1, 0, 0, 5, "reset");
      step(1, 0, 0, 5, "reset");

      step(0, 1, 1, 5, "load5");
      for (int i = 0; i < 12; i++) step(0, 0, 1, 0, "count");

      step(0, 1, 0, 3, "load3");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 9, "hold");
      step(0, 0, 1, 0, "resume");
      step(0, 0, 0, 0, "resume");

      step(0, 1, 0, 7, "load7");
      step(1, 0, 1, 0, "rst_mid");
      step(0, 0, 0, 0, "rst_mid");

      run_count = 1'b1;
      for (int i = 0; i < 1000; i++) step(0, 0, 1, 0, "long");
      run_count = 1'b0;
      check("long_cout_cycles", cout_seen, 100);
      check("long_final_q", int'(q), 0);

      step(0, 1, 1, 12, "oor_load");
      step(0, 0, 1, 0, "oor_wrap");
      step(0, 1, 0, 15, "oor_load15");
      step(0, 0, 0, 0, "oor_hold");
      step(0, 0, 1, 0, "oor_wrap15");
      step(0, 0, 0, 0, "oor_after");

      step(0, 1, 0, 4, "prio_pre");
      step(1, 1, 1, 8, "prio_rst");
      step(0, 1, 0, 9, "prio_pre9");
      step(0, 1, 1, 2, "prio_load");
      step(0, 0, 0, 0, "prio_after");

      for (int i = 0; i < 500; i++) begin
         bit r, l, e;
         r = ($urandom_range(31) == 0);
         l = ($urandom_range(7) == 0);
         e = ($urandom_range(3) != 0);
         step(r, l, e, $urandom_range(15), "rand");
      end

      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
